// File: rtl/vx_priority_drain.sv
// Purpose: latch an N-bit request mask, then emit up to K set bits per beat in priority
//          order, clearing each emitted bit, until the mask is empty.
// Latency: input fire at edge t -> first output beat valid in cycle t+1; one beat per cycle.
// Backpressure: ready_out low freezes every output and pending; a new mask is only accepted
//               while idle or on the cycle the last beat of the current mask fires.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   valid_in, data_in, ready_in
//                     input mask handshake (ready_in depends combinationally on ready_out)
//   valid_out, index_out, lane_valid_out, onehot_out, last_out, ready_out
//                     output beat handshake; lane j index at index_out[j*LN +: LN]
module vx_priority_drain #(
    parameter int N       = 8,
    parameter int K       = 2,
    parameter bit REVERSE = 1'b0,
    parameter int LN      = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [N-1:0]    data_in,
    output logic            ready_in,
    output logic            valid_out,
    output logic [K*LN-1:0] index_out,
    output logic [K-1:0]    lane_valid_out,
    output logic [N-1:0]    onehot_out,
    output logic            last_out,
    input  logic            ready_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t         state;
    logic [N-1:0]   pending;

    // Pick network results.
    logic [N-1:0]   lane_oh   [K];
    logic [LN-1:0]  lane_idx  [K];
    logic [K-1:0]   lane_hit;
    logic [N-1:0]   rem;        // bits still unclaimed after all K stages
    logic [N-1:0]   stage_in;   // bits entering the current stage
    logic [N-1:0]   seen;       // prefix-OR of bits already passed in scan order

    logic           in_fire;
    logic           out_fire;

    // ------------------------------------------------------------------
    // K cascaded first-set-bit stages. Each stage scans its input in
    // priority order with a running prefix-OR: a bit is picked only if no
    // higher-priority bit was set. The picked bit is then removed before
    // the next stage, so stage j yields the (j+1)-th set bit of pending.
    // ------------------------------------------------------------------
    always_comb begin
        stage_in = pending;
        seen     = '0;
        lane_hit = '0;
        for (int j = 0; j < K; j++) begin
            lane_oh[j]  = '0;
            lane_idx[j] = '0;
            seen        = '0;
            if (REVERSE) begin
                for (int i = N - 1; i >= 0; i--) begin
                    lane_oh[j][i] = stage_in[i] & ~seen[0];
                    seen[0]       = seen[0] | stage_in[i];
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    lane_oh[j][i] = stage_in[i] & ~seen[0];
                    seen[0]       = seen[0] | stage_in[i];
                end
            end
            // One-hot to binary; an empty stage encodes to index 0.
            for (int i = 0; i < N; i++) begin
                if (lane_oh[j][i]) begin
                    lane_idx[j] = lane_idx[j] | LN'(i);
                end
            end
            lane_hit[j] = |lane_oh[j];
            stage_in    = stage_in & ~lane_oh[j];
        end
        rem = stage_in;
    end

    // ------------------------------------------------------------------
    // Output beat. Everything is derived from registered state only, so
    // valid_out never sees valid_in combinationally. Outputs are gated by
    // valid_out so the idle values are clean zeros regardless of pending.
    // ------------------------------------------------------------------
    assign valid_out = (state == DRAIN);

    always_comb begin
        index_out      = '0;
        lane_valid_out = '0;
        onehot_out     = '0;
        for (int j = 0; j < K; j++) begin
            if (valid_out && lane_hit[j]) begin
                index_out[j*LN +: LN] = lane_idx[j];
                lane_valid_out[j]     = 1'b1;
                onehot_out            = onehot_out | lane_oh[j];
            end
        end
    end

    // Nothing left after the K stages means popcount(pending) <= K.
    assign last_out = valid_out && (rem == '0);

    // A new mask may slip in on the cycle the final beat leaves, keeping the
    // output stream gap-free between back-to-back masks.
    assign ready_in = !reset &&
                      ((state == IDLE) || (last_out && ready_out));

    assign in_fire  = valid_in && ready_in;
    assign out_fire = valid_out && ready_out;

    // ------------------------------------------------------------------
    // FSM and pending mask.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero mask is accepted and dropped; pending stays empty.
                    if (in_fire && (data_in != '0)) begin
                        pending <= data_in;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (last_out) begin
                            if (in_fire) begin
                                // Bypass: load the next mask directly.
                                pending <= data_in;
                                state   <= (data_in != '0) ? DRAIN : IDLE;
                            end else begin
                                pending <= '0;
                                state   <= IDLE;
                            end
                        end else begin
                            pending <= pending & ~onehot_out;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_priority_drain.sv
// Purpose: directed check of vx_priority_drain with N=8, K=2 in both priority directions.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 unit later.
// Backpressure: ready_out is driven directly by the directed steps.
module tb_vx_priority_drain;

    localparam int N  = 8;
    localparam int K  = 2;
    localparam int LN = 3;

    logic            clk;
    logic            reset;
    logic            valid_in;
    logic [N-1:0]    data_in;
    logic            ready_out;

    logic            ready_in,       r_ready_in;
    logic            valid_out,      r_valid_out;
    logic [K*LN-1:0] index_out,      r_index_out;
    logic [K-1:0]    lane_valid_out, r_lane_valid_out;
    logic [N-1:0]    onehot_out,     r_onehot_out;
    logic            last_out,       r_last_out;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] seen_union;

    vx_priority_drain #(.N(N), .K(K), .REVERSE(1'b0)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .index_out      (index_out),
        .lane_valid_out (lane_valid_out),
        .onehot_out     (onehot_out),
        .last_out       (last_out),
        .ready_out      (ready_out)
    );

    vx_priority_drain #(.N(N), .K(K), .REVERSE(1'b1)) dut_rev (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .ready_in       (r_ready_in),
        .valid_out      (r_valid_out),
        .index_out      (r_index_out),
        .lane_valid_out (r_lane_valid_out),
        .onehot_out     (r_onehot_out),
        .last_out       (r_last_out),
        .ready_out      (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then move 1 unit past it to drive and sample.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane 1 index sits above lane 0 index.
    function automatic logic [31:0] idx2(input int l1, input int l0);
        return 32'((l1 << LN) | l0);
    endfunction

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        ready_out = 1'b0;

        // ---------------- reset ----------------
        step();
        step();
        check("rst_ready_in_low", 32'(ready_in), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_lane_valid", 32'(lane_valid_out), 32'd0);
        check("rst_onehot", 32'(onehot_out), 32'd0);
        check("rst_last", 32'(last_out), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready_in_high", 32'(ready_in), 32'd1);

        // ---------------- mask B2, both directions ----------------
        valid_in  = 1'b1;
        data_in   = 8'b1011_0010;
        ready_out = 1'b1;
        step();
        valid_in = 1'b0;
        #1;
        check("b2_b1_valid", 32'(valid_out), 32'd1);
        check("b2_b1_idx", 32'(index_out), idx2(4, 1));
        check("b2_b1_lv", 32'(lane_valid_out), 32'h3);
        check("b2_b1_oh", 32'(onehot_out), 32'h12);
        check("b2_b1_last", 32'(last_out), 32'd0);
        check("b2_b1_ready_in", 32'(ready_in), 32'd0);
        check("rev_b1_idx", 32'(r_index_out), idx2(5, 7));
        check("rev_b1_oh", 32'(r_onehot_out), 32'hA0);
        check("rev_b1_last", 32'(r_last_out), 32'd0);
        step();
        check("b2_b2_idx", 32'(index_out), idx2(7, 5));
        check("b2_b2_oh", 32'(onehot_out), 32'hA0);
        check("b2_b2_last", 32'(last_out), 32'd1);
        check("b2_b2_ready_in", 32'(ready_in), 32'd1);
        check("rev_b2_idx", 32'(r_index_out), idx2(1, 4));
        check("rev_b2_oh", 32'(r_onehot_out), 32'h12);
        check("rev_b2_last", 32'(r_last_out), 32'd1);
        step();
        check("b2_idle_valid", 32'(valid_out), 32'd0);
        check("rev_idle_valid", 32'(r_valid_out), 32'd0);

        // ---------------- single bit 04 ----------------
        valid_in = 1'b1;
        data_in  = 8'h04;
        step();
        valid_in = 1'b0;
        #1;
        check("m04_valid", 32'(valid_out), 32'd1);
        check("m04_idx", 32'(index_out), 32'd2);
        check("m04_lv", 32'(lane_valid_out), 32'h1);
        check("m04_oh", 32'(onehot_out), 32'h04);
        check("m04_last", 32'(last_out), 32'd1);
        step();
        check("m04_done", 32'(valid_out), 32'd0);

        // ---------------- zero mask ----------------
        valid_in = 1'b1;
        data_in  = 8'h00;
        check("m00_ready_in", 32'(ready_in), 32'd1);
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("m00_no_beat", 32'(valid_out), 32'd0);
            step();
        end
        check("m00_ready_after", 32'(ready_in), 32'd1);

        // ---------------- backpressure on FF ----------------
        ready_out = 1'b0;
        valid_in  = 1'b1;
        data_in   = 8'hFF;
        step();
        valid_in = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 32'(valid_out), 32'd1);
            check("bp_hold_idx", 32'(index_out), idx2(1, 0));
            check("bp_hold_oh", 32'(onehot_out), 32'h03);
            check("bp_hold_ready_in", 32'(ready_in), 32'd0);
            if (i < 2) step();
        end
        ready_out  = 1'b1;
        seen_union = '0;
        #1;
        for (int b = 0; b < 4; b++) begin
            check("bp_beat_oh", 32'(onehot_out), 32'(8'h03 << (2 * b)));
            check("bp_beat_last", 32'(last_out), (b == 3) ? 32'd1 : 32'd0);
            check("bp_no_dup", 32'(seen_union & onehot_out), 32'd0);
            seen_union = seen_union | onehot_out;
            step();
        end
        check("bp_union", 32'(seen_union), 32'hFF);
        check("bp_done", 32'(valid_out), 32'd0);

        // ---------------- back-to-back bypass ----------------
        valid_in = 1'b1;
        data_in  = 8'h03;
        step();
        data_in = 8'hC0;
        #1;
        check("b2b_first_valid", 32'(valid_out), 32'd1);
        check("b2b_first_idx", 32'(index_out), idx2(1, 0));
        check("b2b_first_last", 32'(last_out), 32'd1);
        check("b2b_bypass_ready", 32'(ready_in), 32'd1);
        step();
        valid_in = 1'b0;
        #1;
        check("b2b_second_valid", 32'(valid_out), 32'd1);
        check("b2b_second_idx", 32'(index_out), idx2(7, 6));
        check("b2b_second_oh", 32'(onehot_out), 32'hC0);
        check("b2b_second_last", 32'(last_out), 32'd1);
        step();
        check("b2b_done", 32'(valid_out), 32'd0);

        // ---------------- reset mid-drain ----------------
        valid_in = 1'b1;
        data_in  = 8'hFF;
        step();
        valid_in = 1'b0;
        #1;
        check("mr_b1_oh", 32'(onehot_out), 32'h03);
        step();
        check("mr_b2_oh", 32'(onehot_out), 32'h0C);
        reset = 1'b1;
        #1;
        check("mr_ready_in_in_reset", 32'(ready_in), 32'd0);
        step();
        check("mr_valid_after_rst", 32'(valid_out), 32'd0);
        check("mr_lv_after_rst", 32'(lane_valid_out), 32'd0);
        check("mr_oh_after_rst", 32'(onehot_out), 32'd0);
        check("mr_last_after_rst", 32'(last_out), 32'd0);
        reset = 1'b0;
        #1;
        check("mr_ready_in_post", 32'(ready_in), 32'd1);
        valid_in = 1'b1;
        data_in  = 8'h10;
        step();
        valid_in = 1'b0;
        #1;
        check("mr_new_valid", 32'(valid_out), 32'd1);
        check("mr_new_idx", 32'(index_out), 32'd4);
        check("mr_new_lv", 32'(lane_valid_out), 32'h1);
        check("mr_new_oh", 32'(onehot_out), 32'h10);
        check("mr_new_last", 32'(last_out), 32'd1);
        step();
        check("mr_no_stale_beat", 32'(valid_out), 32'd0);
        step();
        check("mr_still_idle", 32'(valid_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_priority_drain.md
# VX_priority_drain

Sequential multi-pick priority encoder. It latches an N-bit request mask through a valid/ready input handshake, then emits up to K set bits per cycle in priority order through a valid/ready output handshake, clearing each emitted bit. It finishes draining the mask, then accepts the next one. Used by the issue/commit and cache-MSHR paths to serialise sparse lane or entry masks at a configurable throughput, replacing single-pick combinational encoding plus external clear logic.

## Interface

- N, 8: request mask width, ≥1
- K, 2: picks emitted per output beat, 1 ≤ K ≤ N
- REVERSE, 0: 0 gives priority to the lowest index, 1 gives priority to the highest index
- LN, `LOG2UP(N)`: index width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  input mask valid
- data_in  in  N  request mask
- ready_in  out  1  block can accept a mask
- valid_out  out  1  output beat valid
- index_out  out  K*LN  lane j index at bits [j*LN +: LN]
- lane_valid_out  out  K  lane j holds a real pick
- onehot_out  out  N  OR of all valid lanes' one-hot bits
- last_out  out  1  this beat empties the mask
- ready_out  in  1  consumer accepts the beat

## Operation

- State: `pending[N-1:0]` plus FSM {IDLE, DRAIN}.
- IDLE:
  - ready_in=1 and valid_out=0.
  - On an input fire (valid_in&&ready_in) with data_in≠0: pending←data_in, go to DRAIN.
  - On an input fire with data_in==0: the mask is accepted and dropped; no output beat is produced; stay in IDLE.
- DRAIN:
  - valid_out=1.
  - Lane j carries the (j+1)-th set bit of pending in priority order: lowest-first when REVERSE=0, highest-first when REVERSE=1.
  - lane_valid_out[j]=1 iff popcount(pending)>j.
  - Invalid lanes drive index 0.
  - last_out = (popcount(pending) ≤ K).
- Output fire (valid_out&&ready_out):
  - pending ← pending & ~onehot_out.
  - If last_out: go to IDLE. Exception: when an input fire happens in the same cycle, load the new mask directly (see bypass below).
- Bypass: ready_in = IDLE || (DRAIN && last_out && ready_out).
  - A mask accepted on the cycle of the last beat loads into pending.
  - The FSM stays in DRAIN, or goes to IDLE if that mask is zero.
- Stability: with valid_out=1 and ready_out=0, every output holds stable and pending is unchanged.
- ready_in is a combinational function of ready_out. This is the only combinational input-to-output path.
- Picks are computed combinationally from pending by K cascaded first-set-bit stages: stage j masks off stages 0..j-1. K=1 reduces to a single prefix-OR scan.
- N==1: a single lane; index_out=0; last_out=1 whenever valid_out=1.
- Each set bit of an accepted mask is emitted exactly once. No bit is ever emitted that was not in the mask.

## Timing

- Reset (reset=1 at an edge): state=IDLE and pending=0.
  - valid_out=0, lane_valid_out=0, onehot_out=0 and last_out=0 from the following cycle.
  - ready_in is forced to 0 while reset is high and is 1 in the first cycle after it.
- Reset mid-drain discards the remaining pending bits. No further beats are emitted.
- Latency: input fire at edge t gives valid_out=1 in cycle t+1.
- Throughput:
  - A mask with P set bits occupies ceil(P/K) beats with no backpressure.
  - With bypass, back-to-back masks produce beats on every cycle with no idle cycle between them.
- valid_out never depends combinationally on valid_in. Output beats come only from registered pending.
- Simultaneous output fire and input fire on a non-last beat cannot occur, because ready_in=0.

## Test plan

- N=8, K=2, REVERSE=0, data_in=8'b1011_0010, ready_out=1 → beat 1: indices (1,4), lane_valid 2'b11, onehot 8'h12, last 0. Beat 2: indices (5,7), onehot 8'hA0, last 1. Then IDLE.
- Same mask with REVERSE=1 → beats (7,5) then (4,1); last_out=1 on beat 2 only.
- data_in=8'h04, K=2 → a single beat: index0=2, lane_valid 2'b01, last 1. data_in=8'h00 → accepted, no valid_out ever asserted.
- Backpressure: mask 8'hFF with ready_out low for 3 cycles on beat 1 → outputs held identical (indices 0,1) for all 3 cycles. Then 4 beats are emitted; total onehot union = 8'hFF with no duplicates.
- Back-to-back: 8'h03 then 8'hC0 presented continuously → the second mask is accepted on the cycle the first beat fires. Beats appear on consecutive cycles: (0,1) then (6,7).
- Reset asserted during beat 2 of an 8'hFF drain → next cycle valid_out=0. ready_in=1 after reset deasserts. A new mask 8'h10 then yields index 4 one cycle after it is accepted.
